// File: rtl/async_input_conditioner.sv
// Asynchronous input conditioner: per-channel multi-flop synchronizer,
// persistence (debounce) filter, and registered rise/fall edge pulses.
// Every channel is an independent copy. A shared any_change flag reports
// a pulse on any channel in the same cycle as that pulse.
module async_input_conditioner #(
  parameter int WIDTH         = 1,
  parameter int STAGES        = 2,
  parameter int FILTER_CYCLES = 4,
  parameter bit RESET_VAL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  // The counter needs at least one bit, even when FILTER_CYCLES is 1.
  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] change_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic [STAGES-1:0] chain_q;
    logic              filt_q;
    logic              filt_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              rise_q;
    logic              fall_q;

    // Plain shift chain into the clock domain; no logic between stages.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        chain_q <= {STAGES{RESET_VAL}};
      end else begin
        chain_q <= {chain_q[STAGES-2:0], async_in[g]};
      end
    end

    // A new level is accepted only after it has differed from the filtered
    // level for FILTER_CYCLES consecutive edges; any agreement restarts the count.
    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (chain_q[STAGES-1] != filt_q) begin
        if (cnt_q == CNT_MAX) begin
          filt_d = chain_q[STAGES-1];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    // Filter state and edge pulses; a pulse marks the cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt_q <= RESET_VAL;
        cnt_q  <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        filt_q <= filt_d;
        cnt_q  <= cnt_d;
        rise_q <= filt_d & ~filt_q;
        fall_q <= ~filt_d & filt_q;
      end
    end

    assign change_d[g]   = filt_d ^ filt_q;
    assign sync_out[g]   = chain_q[STAGES-1];
    assign filt_out[g]   = filt_q;
    assign rise_pulse[g] = rise_q;
    assign fall_pulse[g] = fall_q;
  end

  // Registered from the same next-state terms as the pulses so it lines up with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |change_d;
    end
  end

endmodule

// File: tb/tb_async_input_conditioner.sv
// Directed bench for async_input_conditioner (WIDTH=4, FILTER_CYCLES=3),
// with a second STAGES=3 instance sharing the same stimulus.
`timescale 1ns/1ps
module tb_async_input_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] async_in;
  logic [3:0] sync_out, filt_out, rise_pulse, fall_pulse;
  logic       any_change;
  logic [3:0] sync_out3, filt_out3, rise_pulse3, fall_pulse3;
  logic       any_change3;

  int n_cmp  = 0;
  int n_fail = 0;

  async_input_conditioner #(
    .WIDTH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VAL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .async_in(async_in),
    .sync_out(sync_out), .filt_out(filt_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .any_change(any_change)
  );

  async_input_conditioner #(
    .WIDTH(4), .STAGES(3), .FILTER_CYCLES(3), .RESET_VAL(1'b0)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .async_in(async_in),
    .sync_out(sync_out3), .filt_out(filt_out3),
    .rise_pulse(rise_pulse3), .fall_pulse(fall_pulse3),
    .any_change(any_change3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous reset entry forces everything low with no clock, and it stays low.
  task automatic test_reset();
    async_in = 4'hF;
    rst_n    = 1'b1;
    #12;
    rst_n = 1'b0;
    #0.1;
    for (int pass = 0; pass < 2; pass++) begin
      n_cmp++;
      if ({sync_out, filt_out, rise_pulse, fall_pulse} !== 16'h0000) begin
        n_fail++;
        $display("[TB] FAIL reset_vec pass %0d: got %h expected 0000", pass,
                 {sync_out, filt_out, rise_pulse, fall_pulse});
      end
      n_cmp++;
      if (any_change !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_any pass %0d: got %b expected 0", pass, any_change);
      end
      n_cmp++;
      if ({sync_out3, filt_out3} !== 8'h00) begin
        n_fail++;
        $display("[TB] FAIL reset_dut3 pass %0d: got %h expected 00", pass, {sync_out3, filt_out3});
      end
      #3.9;
    end
    async_in = 4'h0;
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // Single rising input on channel 0: synchronizer plus filter latency, both depths.
  task automatic test_latency();
    @(posedge clk);
    #7;
    async_in[0] = 1'b1;
    #4;
    for (int k = 0; k <= 6; k++) begin
      n_cmp++;
      if (sync_out[0] !== (k >= 1)) begin
        n_fail++;
        $display("[TB] FAIL lat_sync k=%0d: got %b expected %b", k, sync_out[0], (k >= 1));
      end
      n_cmp++;
      if (filt_out[0] !== (k >= 4)) begin
        n_fail++;
        $display("[TB] FAIL lat_filt k=%0d: got %b expected %b", k, filt_out[0], (k >= 4));
      end
      n_cmp++;
      if ({rise_pulse, fall_pulse, any_change} !== ((k == 4) ? 9'b0001_0000_1 : 9'b0)) begin
        n_fail++;
        $display("[TB] FAIL lat_pulse k=%0d: got %b expected %b", k,
                 {rise_pulse, fall_pulse, any_change}, ((k == 4) ? 9'b0001_0000_1 : 9'b0));
      end
      n_cmp++;
      if ({sync_out3[0], filt_out3[0]} !== {(k >= 2), (k >= 5)}) begin
        n_fail++;
        $display("[TB] FAIL lat3 k=%0d: got %b expected %b", k,
                 {sync_out3[0], filt_out3[0]}, {(k >= 2), (k >= 5)});
      end
      #10;
    end
    async_in = 4'h0;
    repeat (8) @(posedge clk);
  endtask

  // Two-cycle pulse on channel 1 must be rejected entirely.
  task automatic test_glitch();
    @(posedge clk);
    #7;
    async_in[1] = 1'b1;
    #4;
    for (int k = 0; k <= 8; k++) begin
      n_cmp++;
      if (sync_out[1] !== (k == 1 || k == 2)) begin
        n_fail++;
        $display("[TB] FAIL glitch_sync k=%0d: got %b expected %b", k, sync_out[1], (k == 1 || k == 2));
      end
      n_cmp++;
      if ({filt_out[1], rise_pulse[1], fall_pulse[1], any_change} !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL glitch_filt k=%0d: got %b expected 0000", k,
                 {filt_out[1], rise_pulse[1], fall_pulse[1], any_change});
      end
      if (k == 1) begin
        #6;
        async_in[1] = 1'b0;
        #4;
      end else begin
        #10;
      end
    end
  endtask

  // All channels rise together, hold 100 ns, then fall together.
  task automatic test_simultaneous();
    logic [3:0] exp_filt;
    @(posedge clk);
    #7;
    async_in = 4'hF;
    #4;
    for (int k = 0; k <= 16; k++) begin
      exp_filt = (k >= 4 && k < 14) ? 4'hF : 4'h0;
      n_cmp++;
      if (filt_out !== exp_filt) begin
        n_fail++;
        $display("[TB] FAIL simul_filt k=%0d: got %h expected %h", k, filt_out, exp_filt);
      end
      n_cmp++;
      if (rise_pulse !== ((k == 4) ? 4'hF : 4'h0)) begin
        n_fail++;
        $display("[TB] FAIL simul_rise k=%0d: got %h expected %h", k, rise_pulse, ((k == 4) ? 4'hF : 4'h0));
      end
      n_cmp++;
      if (fall_pulse !== ((k == 14) ? 4'hF : 4'h0)) begin
        n_fail++;
        $display("[TB] FAIL simul_fall k=%0d: got %h expected %h", k, fall_pulse, ((k == 14) ? 4'hF : 4'h0));
      end
      n_cmp++;
      if (any_change !== (k == 4 || k == 14)) begin
        n_fail++;
        $display("[TB] FAIL simul_any k=%0d: got %b expected %b", k, any_change, (k == 4 || k == 14));
      end
      if (k == 9) begin
        #6;
        async_in = 4'h0;
        #4;
      end else begin
        #10;
      end
    end
  endtask

  // Reset while channel 2 is two counts in; a full count is required after release.
  task automatic test_reset_mid_count();
    logic exp_sync;
    @(posedge clk);
    #7;
    async_in[2] = 1'b1;
    #4;
    for (int k = 0; k <= 12; k++) begin
      exp_sync = (k >= 1 && k <= 3) || (k >= 7);
      n_cmp++;
      if (sync_out[2] !== exp_sync) begin
        n_fail++;
        $display("[TB] FAIL rmc_sync k=%0d: got %b expected %b", k, sync_out[2], exp_sync);
      end
      n_cmp++;
      if (filt_out[2] !== (k >= 10)) begin
        n_fail++;
        $display("[TB] FAIL rmc_filt k=%0d: got %b expected %b", k, filt_out[2], (k >= 10));
      end
      n_cmp++;
      if ({rise_pulse, fall_pulse, any_change} !== ((k == 10) ? 9'b0100_0000_1 : 9'b0)) begin
        n_fail++;
        $display("[TB] FAIL rmc_pulse k=%0d: got %b expected %b", k,
                 {rise_pulse, fall_pulse, any_change}, ((k == 10) ? 9'b0100_0000_1 : 9'b0));
      end
      if (k == 3) begin
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sync_out[2], filt_out[2], any_change} !== 3'b000) begin
          n_fail++;
          $display("[TB] FAIL rmc_in_reset: got %b expected 000", {sync_out[2], filt_out[2], any_change});
        end
        #7;
      end else if (k == 5) begin
        #2;
        rst_n = 1'b1;
        #8;
      end else begin
        #10;
      end
    end
    async_in = 4'h0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
